// File: rtl/lwb_pkg.sv
// Shared defaults, read-FSM state type and window width helper for line_window_buf.
package lwb_pkg;

   localparam int LWB_DATA_W = 8;
   localparam int LWB_IMG_W  = 28;
   localparam int LWB_K      = 3;
   localparam int LWB_NUM_LB = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_RETIRE = 2'd2
   } lwb_state_t;

   function automatic int win_w(input int k, input int dw);
      return k * k * dw;
   endfunction

endpackage

// File: rtl/lwb_line_ram.sv
// One image line: a single write port and K combinational read ports.
// Contents are intentionally not reset.
module lwb_line_ram
   import lwb_pkg::*;
#(
   parameter int DATA_W = LWB_DATA_W,
   parameter int IMG_W  = LWB_IMG_W,
   parameter int K      = LWB_K,
   parameter int AW     = 5
) (
   input  logic                axi_clk,
   input  logic                we,
   input  logic [AW-1:0]       wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [K*AW-1:0]     rd_addr,
   output logic [K*DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [IMG_W];

   always_ff @(posedge axi_clk) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < K; c++) begin
         rd_data[c*DATA_W +: DATA_W] = mem_q[rd_addr[c*AW +: AW]];
      end
   end

endmodule

// File: rtl/line_window_buf.sv
// Ring of NUM_LB line buffers presenting KxK windows over a valid/ready handshake.
// Optional macro LWB_ZERO_PAD_EN: one window per column with zero-padded borders.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for at least K complete lines
//   ST_RUN    | presenting windows, rd_col advances on each transfer
//   ST_RETIRE | oldest line freed: rd_lb advances, filled drops, o_intr pulses
module line_window_buf
   import lwb_pkg::*;
#(
   parameter int DATA_W = LWB_DATA_W,
   parameter int IMG_W  = LWB_IMG_W,
   parameter int K      = LWB_K,
   parameter int NUM_LB = LWB_NUM_LB
) (
   input  logic                          axi_clk,
   input  logic                          axi_rst_n,
   input  logic                          i_data_valid,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_window_ready,
   output logic                          o_window_valid,
   output logic [win_w(K, DATA_W)-1:0]   o_window,
   output logic                          o_intr,
   output logic                          o_overflow,
   output logic [3:0]                    o_lines_filled
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int LW = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;
`ifdef LWB_ZERO_PAD_EN
   localparam int LAST_COL = IMG_W - 1;
`else
   localparam int LAST_COL = IMG_W - K;
`endif
   localparam logic [CW-1:0] WR_LAST  = CW'(IMG_W - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'(LAST_COL);
   localparam logic [LW-1:0] LB_LAST  = LW'(NUM_LB - 1);
   localparam logic [3:0]    NUM_LB_C = 4'(NUM_LB);
   localparam logic [3:0]    K_C      = 4'(K);

   lwb_state_t      state_q, state_d;
   logic [CW-1:0]   wr_col_q, wr_col_d, rd_col_q, rd_col_d;
   logic [LW-1:0]   wr_lb_q, wr_lb_d, rd_lb_q, rd_lb_d;
   logic [3:0]      filled_q, filled_d;
   logic            overflow_q, overflow_d;
   logic            accept, line_done, retire;

   logic [K*CW-1:0]     rd_addr;
   logic [K-1:0]        col_ok;
   logic [K*DATA_W-1:0] ram_rd [NUM_LB];
   logic [LW:0]         row_sum;
   logic [LW-1:0]       row_lb;
`ifdef LWB_ZERO_PAD_EN
   int                  pad_col;
`endif

   always_comb begin
      accept     = i_data_valid && (filled_q != NUM_LB_C);
      line_done  = accept && (wr_col_q == WR_LAST);
      overflow_d = overflow_q || (i_data_valid && (filled_q == NUM_LB_C));
      wr_col_d   = wr_col_q;
      wr_lb_d    = wr_lb_q;
      if (accept) begin
         if (line_done) begin
            wr_col_d = '0;
            wr_lb_d  = (wr_lb_q == LB_LAST) ? '0 : wr_lb_q + 1'b1;
         end else begin
            wr_col_d = wr_col_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      rd_col_d       = rd_col_q;
      rd_lb_d        = rd_lb_q;
      retire         = 1'b0;
      o_window_valid = 1'b0;
      o_intr         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (filled_q >= K_C) begin
               state_d  = ST_RUN;
               rd_col_d = '0;
            end
         end
         ST_RUN: begin
            o_window_valid = 1'b1;
            if (i_window_ready) begin
               if (rd_col_q == RD_LAST) begin
                  state_d = ST_RETIRE;
               end else begin
                  rd_col_d = rd_col_q + 1'b1;
               end
            end
         end
         ST_RETIRE: begin
            retire  = 1'b1;
            o_intr  = 1'b1;
            rd_lb_d = (rd_lb_q == LB_LAST) ? '0 : rd_lb_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A line completing in the retire cycle cancels the decrement.
   always_comb begin
      filled_d = filled_q;
      if (line_done && !retire) begin
         filled_d = filled_q + 4'd1;
      end else if (retire && !line_done) begin
         filled_d = filled_q - 4'd1;
      end
   end

   always_comb begin
      rd_addr = '0;
      col_ok  = '0;
`ifdef LWB_ZERO_PAD_EN
      pad_col = 0;
`endif
      for (int c = 0; c < K; c++) begin
`ifdef LWB_ZERO_PAD_EN
         pad_col   = int'(rd_col_q) + c - 1;
         col_ok[c] = (pad_col >= 0) && (pad_col < IMG_W);
         rd_addr[c*CW +: CW] = col_ok[c] ? CW'(pad_col) : '0;
`else
         col_ok[c] = 1'b1;
         rd_addr[c*CW +: CW] = rd_col_q + CW'(c);
`endif
      end
   end

   // Output is forced to zero outside RUN so reset clears it immediately.
   always_comb begin
      o_window = '0;
      row_sum  = '0;
      row_lb   = '0;
      if (o_window_valid) begin
         for (int r = 0; r < K; r++) begin
            row_sum = {1'b0, rd_lb_q} + (LW+1)'(r);
            if (row_sum >= (LW+1)'(NUM_LB)) begin
               row_sum = row_sum - (LW+1)'(NUM_LB);
            end
            row_lb = row_sum[LW-1:0];
            for (int c = 0; c < K; c++) begin
               if (col_ok[c]) begin
                  o_window[(r*K+c)*DATA_W +: DATA_W] = ram_rd[row_lb][c*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
      lwb_line_ram #(
         .DATA_W (DATA_W),
         .IMG_W  (IMG_W),
         .K      (K),
         .AW     (CW)
      ) u_ram (
         .axi_clk (axi_clk),
         .we      (accept && (wr_lb_q == LW'(i))),
         .wr_addr (wr_col_q),
         .wr_data (i_data),
         .rd_addr (rd_addr),
         .rd_data (ram_rd[i])
      );
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state_q    <= ST_IDLE;
         wr_col_q   <= '0;
         wr_lb_q    <= '0;
         rd_col_q   <= '0;
         rd_lb_q    <= '0;
         filled_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_col_q   <= wr_col_d;
         wr_lb_q    <= wr_lb_d;
         rd_col_q   <= rd_col_d;
         rd_lb_q    <= rd_lb_d;
         filled_q   <= filled_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_overflow     = overflow_q;
   assign o_lines_filled = filled_q;

endmodule
